// File: rtl/cpu_dbg_pkg.sv
// Shared types for the pipeline trace buffer: FSM encoding, trace entry layout, readout word count.
// TRACE_STALL_CNT_EN adds a 16-bit stall counter field to every entry (3 readout words instead of 2).
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

`ifdef TRACE_STALL_CNT_EN
  localparam int WORDS_PER_ENTRY = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] stall_cnt;
  } trace_entry_t;
`else
  localparam int WORDS_PER_ENTRY = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } trace_entry_t;
`endif

  // Word selector is wide enough for the 3-word layout in both builds.
  localparam int WSEL_W = 2;
  localparam logic [WSEL_W-1:0] WSEL_LAST = WSEL_W'(WORDS_PER_ENTRY - 1);

endpackage

// File: rtl/trace_ram.sv
// DEPTH x trace_entry_t register array: synchronous write, asynchronous read.
// Entry width follows TRACE_STALL_CNT_EN through trace_entry_t.
module trace_ram
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  trace_entry_t     wdata,
  input  logic [PTR_W-1:0] raddr,
  output trace_entry_t     rdata
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Records non-stalled {PC, if_Inst} pairs from the CPU into a trace RAM, then streams them out.
// TRACE_STALL_CNT_EN: each entry also carries the number of stalled CAPTURE cycles before it.
module pipeline_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             arm,
  input  logic             stop,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  input  logic [31:0]      PC,
  input  logic [31:0]      if_Inst,
  input  logic             stall,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [1:0]       state,
  output logic [PTR_W:0]   count
);

  trace_state_t      state_q, state_n;
  logic [PTR_W-1:0]  wptr_q, wptr_n, rptr_q, rptr_n;
  logic [PTR_W:0]    count_q, count_n;
  logic [WSEL_W-1:0] wsel_q, wsel_n;
  logic              we;
  logic              trig_hit;
  trace_entry_t      wentry, rentry;

  // Readout handshake: a word transfers on any edge where rd_valid && rd_ready; rd_valid
  // never depends on rd_ready, and rd_data is held stable until the transfer happens.
  assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
  assign trig_hit = !stall && (PC == trig_pc);
  assign state    = state_q;
  assign count    = count_q;

  always_comb begin
    state_n = state_q;
    wptr_n  = wptr_q;
    rptr_n  = rptr_q;
    count_n = count_q;
    wsel_n  = wsel_q;
    we      = 1'b0;
    if (arm) begin
      state_n = trig_en ? ST_ARMED : ST_CAPTURE;
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
      wsel_n  = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (stop) begin
            state_n = ST_DONE;
          end else if (trig_hit) begin
            we      = 1'b1;
            state_n = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          we = !stall;
          if (stop) state_n = ST_DONE;
        end
        ST_DONE: begin
          if (rd_valid && rd_ready) begin
            if (wsel_q == WSEL_LAST) begin
              wsel_n  = '0;
              rptr_n  = rptr_q + PTR_W'(1);
              count_n = count_q - (PTR_W+1)'(1);
            end else begin
              wsel_n = wsel_q + WSEL_W'(1);
            end
          end
        end
        default: ;
      endcase
      // The write that fills the buffer closes the session on the same edge.
      if (we) begin
        wptr_n  = wptr_q + PTR_W'(1);
        count_n = count_q + (PTR_W+1)'(1);
        if (count_q == (PTR_W+1)'(DEPTH - 1)) state_n = ST_DONE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wsel_q  <= '0;
    end else begin
      state_q <= state_n;
      wptr_q  <= wptr_n;
      rptr_q  <= rptr_n;
      count_q <= count_n;
      wsel_q  <= wsel_n;
    end
  end

`ifdef TRACE_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // The value written is the count accumulated so far; the counter restarts in the write cycle.
  always_ff @(posedge Clock) begin
    if (Reset || arm) begin
      stall_cnt <= '0;
    end else if (we) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_CAPTURE) && stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign wentry = '{pc: PC, inst: if_Inst, stall_cnt: stall_cnt};
`else
  assign wentry = '{pc: PC, inst: if_Inst};
`endif

  trace_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (Clock),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wentry),
    .raddr (rptr_q),
    .rdata (rentry)
  );

  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      case (wsel_q)
        2'd0:    rd_data = rentry.pc;
        2'd1:    rd_data = rentry.inst;
`ifdef TRACE_STALL_CNT_EN
        2'd2:    rd_data = {16'h0, rentry.stall_cnt};
`endif
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer; the reference model holds the expected readout
// stream as a word queue. Works with or without TRACE_STALL_CNT_EN.
module tb_pipeline_trace_buffer;
  import cpu_dbg_pkg::*;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic           arm = 1'b0, stop = 1'b0, trig_en = 1'b0, stall = 1'b0, rd_ready = 1'b0;
  logic [31:0]    trig_pc = '0, PC = '0, if_Inst = '0;
  logic [31:0]    rd_data;
  logic           rd_valid;
  logic [1:0]     state;
  logic [PTR_W:0] count;

  pipeline_trace_buffer #(.DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .arm      (arm),
    .stop     (stop),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .PC       (PC),
    .if_Inst  (if_Inst),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .state    (state),
    .count    (count)
  );

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [1:0]  m_state  = 2'd0;
  logic [31:0] exp_q[$];
  int          m_scnt   = 0;

  function automatic int m_entries();
    return (exp_q.size() + WORDS_PER_ENTRY - 1) / WORDS_PER_ENTRY;
  endfunction

  function automatic logic [PTR_W:0] exp_count();
    return (PTR_W+1)'(m_entries());
  endfunction

  function automatic logic exp_valid();
    return (m_state == 2'd3) && (exp_q.size() != 0);
  endfunction

  function automatic logic [31:0] exp_data();
    return exp_valid() ? exp_q[0] : 32'h0;
  endfunction

  task automatic m_push();
    exp_q.push_back(PC);
    exp_q.push_back(if_Inst);
    if (WORDS_PER_ENTRY == 3) exp_q.push_back({16'h0, 16'(m_scnt)});
    m_scnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    if (Reset) begin
      m_state = 2'd0; exp_q.delete(); m_scnt = 0;
    end else if (arm) begin
      m_state = trig_en ? 2'd1 : 2'd2; exp_q.delete(); m_scnt = 0;
    end else begin
      case (m_state)
        2'd1: begin
          if (stop) m_state = 2'd3;
          else if (!stall && PC == trig_pc) begin
            m_push();
            m_state = (m_entries() == DEPTH) ? 2'd3 : 2'd2;
          end
        end
        2'd2: begin
          if (!stall) m_push();
          else if (m_scnt < 65535) m_scnt++;
          if (stop || m_entries() == DEPTH) m_state = 2'd3;
        end
        2'd3: if (exp_valid() && rd_ready) void'(exp_q.pop_front());
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 1'b0; stop = 1'b0; stall = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic do_arm(input logic te, input logic [31:0] tpc);
    idle_inputs();
    arm = 1'b1; trig_en = te; trig_pc = tpc;
    step();
    arm = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    n_checks += 4;
    if (state !== 2'd0) begin n_fails++; $display("FAIL reset_state: got %0d want 0", state); end
    if (count !== '0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", count); end
    if (rd_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    if (rd_data !== 32'h0) begin n_fails++; $display("FAIL reset_data: got %h want 0", rd_data); end
    // IDLE must ignore stop and a matching PC.
    stop = 1'b1; trig_pc = 32'h40; PC = 32'h40;
    step();
    stop = 1'b0;
    n_checks += 2;
    if (state !== 2'd0) begin n_fails++; $display("FAIL idle_ignore_state: got %0d want 0", state); end
    if (count !== '0) begin n_fails++; $display("FAIL idle_ignore_count: got %0d want 0", count); end
  endtask

  task automatic test_readout(input int mode);
    int          budget = 400;
    int          k = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    while (exp_q.size() != 0 && budget > 0) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 2 == 0);
        default: rd_ready = ($urandom_range(0, 2) != 0);
      endcase
      n_checks += 4;
      if (state !== m_state) begin n_fails++; $display("FAIL rd_state: got %0d want %0d", state, m_state); end
      if (count !== exp_count()) begin n_fails++; $display("FAIL rd_count: got %0d want %0d", count, exp_count()); end
      if (rd_valid !== exp_valid()) begin n_fails++; $display("FAIL rd_valid: got %b want %b", rd_valid, exp_valid()); end
      if (rd_data !== exp_data()) begin n_fails++; $display("FAIL rd_data: got %h want %h", rd_data, exp_data()); end
      if (prev_hold) begin
        n_checks++;
        if (rd_data !== prev_data) begin n_fails++; $display("FAIL rd_hold: got %h want %h", rd_data, prev_data); end
      end
      prev_hold = !rd_ready;
      prev_data = exp_data();
      step();
      k++;
      budget--;
    end
    rd_ready = 1'b0;
    n_checks += 4;
    if (budget == 0) begin n_fails++; $display("FAIL rd_timeout: got %0d words left want 0", exp_q.size()); end
    if (count !== '0) begin n_fails++; $display("FAIL rd_end_count: got %0d want 0", count); end
    if (state !== 2'd3) begin n_fails++; $display("FAIL rd_end_state: got %0d want 3", state); end
    if (rd_valid !== 1'b0) begin n_fails++; $display("FAIL rd_end_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_immediate_capture();
    do_arm(1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      PC = 32'(i * 4); if_Inst = $urandom; stall = 1'b0;
      n_checks += 2;
      if (state !== m_state) begin n_fails++; $display("FAIL imm_state: got %0d want %0d", state, m_state); end
      if (count !== exp_count()) begin n_fails++; $display("FAIL imm_count: got %0d want %0d", count, exp_count()); end
      step();
    end
    n_checks += 4;
    if (state !== 2'd3) begin n_fails++; $display("FAIL imm_full_state: got %0d want 3", state); end
    if (count !== 5'd16) begin n_fails++; $display("FAIL imm_full_count: got %0d want 16", count); end
    if (rd_data !== 32'h0) begin n_fails++; $display("FAIL imm_first_word: got %h want 00000000", rd_data); end
    if (exp_q.size() != 16 * WORDS_PER_ENTRY) begin n_fails++; $display("FAIL imm_words: got %0d want %0d", exp_q.size(), 16 * WORDS_PER_ENTRY); end
    // Extra non-stalled cycles in DONE must not overwrite anything.
    PC = 32'h0BAD_0000;
    step();
    test_readout(0);
  endtask

  task automatic test_trigger();
    do_arm(1'b1, 32'h20);
    n_checks++;
    if (state !== 2'd1) begin n_fails++; $display("FAIL trig_armed: got %0d want 1", state); end
    for (int i = 0; i <= 10; i++) begin
      PC = 32'(i * 4); if_Inst = $urandom; stall = 1'b0;
      n_checks += 2;
      if (state !== m_state) begin n_fails++; $display("FAIL trig_state: got %0d want %0d", state, m_state); end
      if (count !== exp_count()) begin n_fails++; $display("FAIL trig_count: got %0d want %0d", count, exp_count()); end
      step();
    end
    stop = 1'b1; stall = 1'b1; PC = 32'h2C;
    step();
    stop = 1'b0; stall = 1'b0;
    n_checks += 3;
    if (state !== 2'd3) begin n_fails++; $display("FAIL trig_stop_state: got %0d want 3", state); end
    if (count !== 5'd3) begin n_fails++; $display("FAIL trig_stop_count: got %0d want 3", count); end
    if (rd_data !== 32'h20) begin n_fails++; $display("FAIL trig_first_pc: got %h want 00000020", rd_data); end
    test_readout(0);
  endtask

  task automatic test_stall_backpressure();
    logic [31:0] pcs [7] = '{32'h0C, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h14};
    logic        sts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_arm(1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 7; i++) begin
      PC = pcs[i]; stall = sts[i]; if_Inst = $urandom;
      stop = (i == 6);  // stop together with a due write keeps that write
      step();
    end
    idle_inputs();
    n_checks += 2;
    if (count !== 5'd3) begin n_fails++; $display("FAIL stall_count: got %0d want 3", count); end
    if (state !== 2'd3) begin n_fails++; $display("FAIL stall_state: got %0d want 3", state); end
    if (WORDS_PER_ENTRY == 3) begin
      n_checks++;
      if (exp_q[5] !== 32'h4) begin n_fails++; $display("FAIL stall_cnt_word: got %h want 00000004", exp_q[5]); end
    end
    test_readout(1);
  endtask

  task automatic test_arm_mid_readout();
    do_arm(1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      PC = $urandom; if_Inst = $urandom; stall = 1'b0;
      step();
    end
    stop = 1'b1; stall = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (count !== 5'd5) begin n_fails++; $display("FAIL mid_count5: got %0d want 5", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_data !== exp_data()) begin n_fails++; $display("FAIL mid_data: got %h want %h", rd_data, exp_data()); end
      step();
    end
    arm = 1'b1; trig_en = 1'b1; trig_pc = 32'hDEAD_BEEF; rd_ready = 1'b1;
    step();
    idle_inputs();
    n_checks += 4;
    if (count !== '0) begin n_fails++; $display("FAIL mid_arm_count: got %0d want 0", count); end
    if (state !== 2'd1) begin n_fails++; $display("FAIL mid_arm_state: got %0d want 1", state); end
    if (rd_valid !== 1'b0) begin n_fails++; $display("FAIL mid_arm_valid: got %b want 0", rd_valid); end
    if (rd_data !== 32'h0) begin n_fails++; $display("FAIL mid_arm_data: got %h want 0", rd_data); end
    // stop while ARMED ends the session empty.
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks += 2;
    if (state !== 2'd3) begin n_fails++; $display("FAIL armed_stop_state: got %0d want 3", state); end
    if (rd_valid !== 1'b0) begin n_fails++; $display("FAIL armed_stop_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_arm(1'($urandom_range(0, 1)), 32'h10);
      for (int c = 0; c < 40; c++) begin
        PC = 32'(4 * $urandom_range(0, 7)); if_Inst = $urandom;
        stall = ($urandom_range(0, 9) < 3);
        stop = ($urandom_range(0, 49) == 0);
        n_checks += 2;
        if (state !== m_state) begin n_fails++; $display("FAIL rnd_state: got %0d want %0d", state, m_state); end
        if (count !== exp_count()) begin n_fails++; $display("FAIL rnd_count: got %0d want %0d", count, exp_count()); end
        step();
      end
      stop = 1'b1;
      step();
      idle_inputs();
      test_readout(2);
    end
    // Reset mid-capture discards the session.
    do_arm(1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin PC = $urandom; step(); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks += 3;
    if (state !== 2'd0) begin n_fails++; $display("FAIL rst_mid_state: got %0d want 0", state); end
    if (count !== '0) begin n_fails++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    if (rd_valid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_valid: got %b want 0", rd_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_immediate_capture();
    test_trigger();
    test_stall_backpressure();
    test_arm_mid_readout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
